counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Segment sequencer that programs and drives the 8-bit programmable counter datapath.
- Software loads a small table of count segments (start value, limit, direction) through a valid/ready command port.
- The block then issues load and count-enable strobes to the counter, runs each segment until the counter reaches its limit, and advances through the table, optionally looping.
- It sits between the `ui_in`/`uio_in` decode logic of the top-level wrapper and the counter core.

## Interface
Parameters
- `WIDTH`, 8: counter width.
- `NSEG`, 4: number of segment table entries (power of 2).

Ports
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; 0 freezes all state.
- `cmd_valid` in 1: command strobe.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`; equals `ena`.
- `cmd_op` in 2: 00 WRITE_SEG, 01 START, 10 STOP, 11 CLEAR.
- `cmd_seg` in clog2(NSEG):
  - WRITE_SEG: entry index.
  - START: index of the last segment to run.
- `cmd_start` in WIDTH: segment start value.
- `cmd_limit` in WIDTH: segment limit value.
- `cmd_dir` in 1: 1 = up, 0 = down.
- `cmd_repeat` in 1: START only; loop the schedule forever.
- `cnt_val` in WIDTH: current counter value from the datapath.
- `cnt_load` out 1: load strobe to the counter.
- `cnt_load_val` out WIDTH: load value.
- `cnt_en` out 1: count enable.
- `cnt_up` out 1: count direction.
- `busy` out 1: schedule running.
- `seg_idx` out clog2(NSEG): active segment.
- `seg_done` out 1: one-cycle pulse when a segment reaches its limit.
- `done` out 1: one-cycle pulse on completion of the last segment (non-repeat runs only).
- `err` out 1: one-cycle pulse when START is received while busy.

## Operation
- Segment table entries are `{start, limit, dir}`; reset/CLEAR value is `{0, 0, 1}`.
- FSM states are IDLE, LOAD and RUN.
- IDLE:
  - WRITE_SEG writes `table[cmd_seg]`.
  - START latches `last=cmd_seg` and `repeat=cmd_repeat`, sets `seg_idx=0`, and goes to LOAD.
  - STOP is a no-op.
- LOAD:
  - Drives `cnt_load=1` and `cnt_load_val=table[seg_idx].start`.
  - Goes to RUN on the next cycle.
- RUN:
  - `cnt_up=table[seg_idx].dir`.
  - `cnt_en = (cnt_val != table[seg_idx].limit)`.
  - On a match, `seg_done=1`:
    - if `seg_idx != last`: `seg_idx+1`, go to LOAD;
    - else if `repeat`: `seg_idx=0`, go to LOAD;
    - else: `done=1`, go to IDLE.
- Outside LOAD/RUN, `cnt_en=0` and `cnt_load=0`. `cnt_up` and `cnt_load_val` always reflect `table[seg_idx]`.
- Busy-state commands:
  - WRITE_SEG while busy writes the table; the new values take effect at that entry's next LOAD.
  - START while busy is ignored and pulses `err`.
- STOP (any state):
  - `cnt_en` and `cnt_load` are forced to 0 in the accepting cycle.
  - The FSM goes to IDLE; `done` and `seg_done` are not pulsed; the counter holds its value.
- CLEAR:
  - Resets the table, `seg_idx`, `last` and `repeat`, and goes to IDLE.
  - Drives `cnt_load=1` with `cnt_load_val=0` in the accepting cycle.
- Simultaneous events:
  - STOP/CLEAR accepted in the same cycle as a RUN match: STOP/CLEAR wins, and `seg_done`/`done` are suppressed.
- Wrap-around: the counter wraps modulo 2^WIDTH; the controller only compares for equality. An up segment 250→2 runs through 255→0.
- `ena=0`: the FSM, table and indices hold; `cnt_en`, `cnt_load`, `seg_done`, `done` and `err` are 0.
- Reset state and output values:
  - State: IDLE, table cleared, `seg_idx=0`, `last=0`, `repeat=0`.
  - Outputs: `cnt_load=0`, `cnt_load_val=0`, `cnt_en=0`, `cnt_up=1`, `busy=0`, `seg_done=0`, `done=0`, `err=0`.
  - `cmd_ready` follows `ena`.
- Reset mid-run returns to these values immediately (asynchronously).

## Timing
- Accepted START → LOAD in the next cycle.
- Counter holds S in the first RUN cycle.
- Cycles per segment:
  - d = (L−S) mod 2^WIDTH for up segments, (S−L) mod 2^WIDTH for down segments.
  - LOAD: 1 cycle.
  - RUN: d+1 cycles, with `cnt_en` high for d of them.
- `seg_done`/`done` are combinational in the RUN match cycle.
- `busy` = (state != IDLE), registered; it drops in the cycle after the match.
- S == L gives a one-cycle RUN with `cnt_en=0`.

## Structure
- Package `counter_seq_pkg`:
  - state enum (IDLE/LOAD/RUN);
  - `cmd_op` encodings;
  - segment struct `{start, limit, dir}`;
  - default `WIDTH`/`NSEG`.
- Sub-module `counter_seq_table`: segment register file with one synchronous write port, one combinational read port indexed by `seg_idx`, and a synchronous clear.
- FSM, compare and strobe logic live in the top.

## Test plan
- Reset with `ena=1` → all outputs at reset values, `cmd_ready=1`; assert/deassert `rst_n` mid-RUN → `cnt_en=0` and `busy=0` immediately.
- WRITE_SEG 0 {3,7,up}, START last=0 → 1 LOAD cycle (`cnt_load_val=3`), RUN sees 3,4,5,6 with `cnt_en=1`, then 7 with `cnt_en=0` and `seg_done=done=1`; `busy=0` next cycle.
- Seg0 {250,2,up}, seg1 {2,0,down}, START last=1 → 8 enabled cycles (wrap through 255→0), `seg_done`, LOAD 2, 2 down steps, `done` once.
- Seg0 {0,1,up}, START repeat=1 → LOAD/RUN/RUN period of 3 cycles with `seg_done` each period and no `done`; STOP → `cnt_en=0` that cycle, `busy=0` next, counter holds.
- START while busy → `err` pulse, schedule unaffected; STOP in the same cycle as the last-segment match → no `done`, IDLE.
- `ena=0` for 3 cycles mid-RUN → `cnt_en=0`, `seg_idx` and state hold, and the run resumes exactly afterward; CLEAR → `cnt_load=1`, `cnt_load_val=0`, table reads `{0,0,1}`.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and encodings for the counter segment sequencer.
package counter_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NSEG  = 4;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Command opcodes on cmd_op
  localparam logic [1:0] OP_WRITE_SEG = 2'b00;
  localparam logic [1:0] OP_START     = 2'b01;
  localparam logic [1:0] OP_STOP      = 2'b10;
  localparam logic [1:0] OP_CLEAR     = 2'b11;

  // One segment table entry at the default counter width; dir=1 counts up
  typedef struct packed {
    logic [DEF_WIDTH-1:0] start;
    logic [DEF_WIDTH-1:0] limit;
    logic                 dir;
  } seg_t;

endpackage

// File: rtl/counter_seq_table.sv
// Segment register file: one synchronous write port, one combinational
// read port, synchronous clear back to {0, 0, up}.
module counter_seq_table
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSEG  = DEF_NSEG,
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [SW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_start,
  input  logic [WIDTH-1:0] wr_limit,
  input  logic             wr_dir,
  input  logic [SW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_start,
  output logic [WIDTH-1:0] rd_limit,
  output logic             rd_dir
);

  logic [WIDTH-1:0] start_arr [NSEG];
  logic [WIDTH-1:0] limit_arr [NSEG];
  logic             dir_arr   [NSEG];

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_entry
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] limit_reg;
    logic             dir_reg;

    // Entry storage: clear has priority over a write to this entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        start_reg <= '0;
        limit_reg <= '0;
        dir_reg   <= 1'b1;
      end else if (clr) begin
        start_reg <= '0;
        limit_reg <= '0;
        dir_reg   <= 1'b1;
      end else if (we && (wr_idx == SW'(gi))) begin
        start_reg <= wr_start;
        limit_reg <= wr_limit;
        dir_reg   <= wr_dir;
      end
    end

    assign start_arr[gi] = start_reg;
    assign limit_arr[gi] = limit_reg;
    assign dir_arr[gi]   = dir_reg;
  end

  assign rd_start = start_arr[rd_idx];
  assign rd_limit = limit_arr[rd_idx];
  assign rd_dir   = dir_arr[rd_idx];

endmodule

// File: rtl/counter_seq_ctrl.sv
// Segment sequencer: loads the counter with each segment's start value,
// enables counting until the counter equals the segment limit, then steps
// through the table, optionally looping.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSEG  = DEF_NSEG,
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SW-1:0]    cmd_seg,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_dir,
  input  logic             cmd_repeat,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic [SW-1:0]    seg_idx,
  output logic             seg_done,
  output logic             done,
  output logic             err
);

  state_t           state_reg, state_next;
  logic [SW-1:0]    seg_idx_reg, seg_idx_next;
  logic [SW-1:0]    last_reg, last_next;
  logic             repeat_reg, repeat_next;
  logic             busy_reg;

  logic             cmd_acc;
  logic             tbl_we, tbl_clr;
  logic [WIDTH-1:0] rd_start, rd_limit;
  logic             rd_dir;
  logic             match;

  counter_seq_table #(.WIDTH(WIDTH), .NSEG(NSEG)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tbl_clr),
    .we       (tbl_we),
    .wr_idx   (cmd_seg),
    .wr_start (cmd_start),
    .wr_limit (cmd_limit),
    .wr_dir   (cmd_dir),
    .rd_idx   (seg_idx_reg),
    .rd_start (rd_start),
    .rd_limit (rd_limit),
    .rd_dir   (rd_dir)
  );

  assign cmd_ready = ena;
  assign cmd_acc   = cmd_valid & ena;
  // Equality only: wrap-around segments fall out of the counter's modulo arithmetic
  assign match     = (cnt_val == rd_limit);
  assign cnt_up    = rd_dir;
  assign busy      = busy_reg;
  assign seg_idx   = seg_idx_reg;

  // State and schedule registers; everything freezes while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      seg_idx_reg <= '0;
      last_reg    <= '0;
      repeat_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      seg_idx_reg <= seg_idx_next;
      last_reg    <= last_next;
      repeat_reg  <= repeat_next;
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  // Next-state, counter strobes and status pulses; STOP/CLEAR override the FSM
  always_comb begin
    state_next   = state_reg;
    seg_idx_next = seg_idx_reg;
    last_next    = last_reg;
    repeat_next  = repeat_reg;
    cnt_load     = 1'b0;
    cnt_load_val = rd_start;
    cnt_en       = 1'b0;
    seg_done     = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    tbl_we       = 1'b0;
    tbl_clr      = 1'b0;
    if (ena) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cmd_acc && (cmd_op == OP_START)) begin
            last_next    = cmd_seg;
            repeat_next  = cmd_repeat;
            seg_idx_next = '0;
            state_next   = ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_load   = 1'b1;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          cnt_en = !match;
          if (match) begin
            seg_done = 1'b1;
            if (seg_idx_reg != last_reg) begin
              seg_idx_next = seg_idx_reg + SW'(1);
              state_next   = ST_LOAD;
            end else if (repeat_reg) begin
              seg_idx_next = '0;
              state_next   = ST_LOAD;
            end else begin
              done       = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase

      if (cmd_acc) begin
        case (cmd_op)
          OP_WRITE_SEG: tbl_we = 1'b1;
          OP_START:     err = (state_reg != ST_IDLE);
          OP_STOP: begin
            state_next   = ST_IDLE;
            seg_idx_next = seg_idx_reg;
            cnt_en       = 1'b0;
            cnt_load     = 1'b0;
            seg_done     = 1'b0;
            done         = 1'b0;
          end
          OP_CLEAR: begin
            tbl_clr      = 1'b1;
            state_next   = ST_IDLE;
            seg_idx_next = '0;
            last_next    = '0;
            repeat_next  = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
            cnt_en       = 1'b0;
            seg_done     = 1'b0;
            done         = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with an emulated counter datapath.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [SW-1:0] cmd_seg;
  logic [W-1:0]  cmd_start;
  logic [W-1:0]  cmd_limit;
  logic          cmd_dir;
  logic          cmd_repeat;
  logic [W-1:0]  cnt_val;
  logic          cnt_load;
  logic [W-1:0]  cnt_load_val;
  logic          cnt_en;
  logic          cnt_up;
  logic          busy;
  logic [SW-1:0] seg_idx;
  logic          seg_done;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  counter_seq_ctrl #(.WIDTH(W), .NSEG(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_seg(cmd_seg), .cmd_start(cmd_start), .cmd_limit(cmd_limit),
    .cmd_dir(cmd_dir), .cmd_repeat(cmd_repeat), .cnt_val(cnt_val),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
    .cnt_up(cnt_up), .busy(busy), .seg_idx(seg_idx), .seg_done(seg_done),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Emulated counter datapath driven by the DUT strobes
  logic [W-1:0] cnt_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign cnt_val = cnt_q;

  // Reference model: segment table contents and expected per-cycle trace
  seg_t mdl_tab [N];

  typedef struct packed {
    logic         load;
    logic [W-1:0] lval;
    logic         en;
    logic         up;
    logic         sd;
    logic         dn;
    logic         bsy;
    logic [SW-1:0] idx;
    logic [W-1:0] cv;
  } obs_t;

  obs_t exp_q[$];

  function automatic void mdl_clear();
    for (int i = 0; i < N; i++) mdl_tab[i] = '{start: 8'd0, limit: 8'd0, dir: 1'b1};
  endfunction

  // Expected cycles of a non-repeating run over segments 0..last:
  // one LOAD cycle then d+1 RUN cycles per segment, d = distance mod 256.
  function automatic void build_trace(input int last, input logic [W-1:0] prev);
    seg_t sg;
    int   d;
    logic [W-1:0] cv;
    exp_q.delete();
    cv = prev;
    for (int i = 0; i <= last; i++) begin
      sg = mdl_tab[i];
      d  = sg.dir ? int'(8'(sg.limit - sg.start)) : int'(8'(sg.start - sg.limit));
      exp_q.push_back({1'b1, sg.start, 1'b0, sg.dir, 1'b0, 1'b0, 1'b1, SW'(i), cv});
      for (int k = 0; k <= d; k++) begin
        cv = sg.dir ? 8'(sg.start + 8'(k)) : 8'(sg.start - 8'(k));
        exp_q.push_back({1'b0, sg.start, (k < d), sg.dir, (k == d), (k == d && i == last),
                         1'b1, SW'(i), cv});
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [SW-1:0] seg, input logic [W-1:0] s,
                      input logic [W-1:0] l, input logic d, input logic r);
    cmd_valid = 1'b1; cmd_op = op; cmd_seg = seg;
    cmd_start = s; cmd_limit = l; cmd_dir = d; cmd_repeat = r;
  endtask

  task automatic write_seg(input int idx, input logic [W-1:0] s, input logic [W-1:0] l,
                           input logic d);
    send(OP_WRITE_SEG, SW'(idx), s, l, d, 1'b0);
    mdl_tab[idx] = '{start: s, limit: l, dir: d};
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seg = '0;
    cmd_start = '0; cmd_limit = '0; cmd_dir = 1'b0; cmd_repeat = 1'b0;
    mdl_clear();
    tick(); tick();
    @(negedge clk);
    total++; if ({cnt_load, cnt_en, busy, seg_done, done, err} !== 6'b0) begin bad++;
      $display("FAIL reset_strobes got=%b want=000000", {cnt_load, cnt_en, busy, seg_done, done, err}); end
    total++; if (cnt_load_val !== 8'd0) begin bad++;
      $display("FAIL reset_load_val got=%0d want=0", cnt_load_val); end
    total++; if (cnt_up !== 1'b1 || seg_idx !== 2'd0) begin bad++;
      $display("FAIL reset_up_idx got up=%b idx=%0d want up=1 idx=0", cnt_up, seg_idx); end
    total++; if (cmd_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    ena = 1'b0; #1;
    total++; if (cmd_ready !== 1'b0) begin bad++;
      $display("FAIL ready_follows_ena got=%b want=0", cmd_ready); end
    ena = 1'b1;
    rst_n = 1'b1;
    tick();
    $display("test_reset finished");
  endtask

  task automatic test_schedule();
    int last, d, nseen;
    logic [W-1:0] s;
    obs_t obs;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        last = 0; write_seg(0, 8'd3, 8'd7, 1'b1);
      end else if (c == 1) begin
        last = 1; write_seg(0, 8'd250, 8'd2, 1'b1); write_seg(1, 8'd2, 8'd0, 1'b0);
      end else begin
        last = $urandom_range(0, 3);
        for (int i = 0; i <= last; i++) begin
          s = 8'($urandom_range(0, 255));
          d = $urandom_range(0, 12);
          if ($urandom_range(0, 1) == 1) write_seg(i, s, 8'(s + 8'(d)), 1'b1);
          else                           write_seg(i, s, 8'(s - 8'(d)), 1'b0);
        end
      end
      send(OP_START, SW'(last), 8'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      build_trace(last, cnt_q);
      total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL start_idle case=%0d got err=%b busy=%b want 0 0", c, err, busy); end
      tick();
      cmd_valid = 1'b0;
      nseen = exp_q.size();
      while (exp_q.size() > 0) begin
        @(negedge clk);
        obs = {cnt_load, cnt_load_val, cnt_en, cnt_up, seg_done, done, busy, seg_idx, cnt_val};
        total++; if (obs !== exp_q[0]) begin bad++;
          $display("FAIL trace case=%0d left=%0d got=%h want=%h", c, exp_q.size(), obs, exp_q[0]); end
        void'(exp_q.pop_front());
        tick();
      end
      @(negedge clk);
      total++; if ({busy, cnt_en, cnt_load, done} !== 4'b0) begin bad++;
        $display("FAIL after_done case=%0d got=%b want=0000", c, {busy, cnt_en, cnt_load, done}); end
      tick();
      $display("schedule case=%0d last=%0d cycles=%0d", c, last, nseen);
    end
  endtask

  task automatic test_repeat();
    int p;
    write_seg(0, 8'd0, 8'd1, 1'b1);
    send(OP_START, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      p = k % 3;
      if (k == 10) send(OP_STOP, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      if (k < 10) begin
        total++; if ({cnt_load, cnt_en, seg_done, done, busy} !== {p == 0, p == 1, p == 2, 1'b0, 1'b1}) begin bad++;
          $display("FAIL repeat_phase k=%0d got=%b want=%b", k, {cnt_load, cnt_en, seg_done, done, busy},
                   {p == 0, p == 1, p == 2, 1'b0, 1'b1}); end
        if (p != 0) begin
          total++; if (cnt_val !== 8'(p - 1)) begin bad++;
            $display("FAIL repeat_cnt k=%0d got=%0d want=%0d", k, cnt_val, p - 1); end
        end
      end else begin
        total++; if ({cnt_en, cnt_load, seg_done, done} !== 4'b0) begin bad++;
          $display("FAIL stop_strobes got=%b want=0000", {cnt_en, cnt_load, seg_done, done}); end
      end
      tick();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || cnt_val !== 8'd0 || cnt_en !== 1'b0) begin bad++;
        $display("FAIL stop_hold k=%0d got busy=%b cnt=%0d en=%b want 0 0 0", k, busy, cnt_val, cnt_en); end
      tick();
    end
    $display("test_repeat finished");
  endtask

  task automatic test_busy_err();
    logic [W-1:0] s;
    int d;
    s = 8'($urandom_range(0, 255));
    d = $urandom_range(2, 10);
    write_seg(0, s, 8'(s + 8'(d)), 1'b1);
    // START while running: err pulse, schedule continues
    send(OP_START, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c <= d + 2; c++) begin
      if (c == 2) send(OP_START, 2'd3, 8'd0, 8'd0, 1'b0, 1'b1);
      else        cmd_valid = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        total++; if (err !== 1'b1 || cnt_en !== 1'b1 || cnt_val !== 8'(s + 8'd1)) begin bad++;
          $display("FAIL err_pulse got err=%b en=%b cnt=%0d want 1 1 %0d", err, cnt_en, cnt_val, 8'(s + 8'd1)); end
      end
      if (c == 3) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_once got=%b want=0", err); end
      end
      if (c == d + 1) begin
        total++; if ({seg_done, done} !== 2'b11) begin bad++;
          $display("FAIL err_run_done got=%b want=11", {seg_done, done}); end
      end
      if (c == d + 2) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_run_idle got=%b want=0", busy); end
      end
      tick();
    end
    // STOP coinciding with the last-segment match
    send(OP_START, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c <= d + 4; c++) begin
      if (c == d + 1) send(OP_STOP, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      else            cmd_valid = 1'b0;
      @(negedge clk);
      if (c == d + 1) begin
        total++; if ({seg_done, done, cnt_en, cnt_load} !== 4'b0 || cnt_val !== 8'(s + 8'(d))) begin bad++;
          $display("FAIL stop_at_match got=%b cnt=%0d want=0000 cnt=%0d",
                   {seg_done, done, cnt_en, cnt_load}, cnt_val, 8'(s + 8'(d))); end
      end
      if (c > d + 1) begin
        total++; if (busy !== 1'b0 || done !== 1'b0 || cnt_val !== 8'(s + 8'(d))) begin bad++;
          $display("FAIL stop_match_idle c=%0d got busy=%b done=%b cnt=%0d", c, busy, done, cnt_val); end
      end
      tick();
    end
    $display("test_busy_err finished start=%0d dist=%0d", s, d);
  endtask

  task automatic test_ena();
    logic [W-1:0] s0, s;
    int got;
    s0 = 8'($urandom_range(0, 255));
    s  = 8'($urandom_range(0, 255));
    write_seg(0, s0, s0, 1'b1);
    write_seg(1, s, 8'(s + 8'd10), 1'b1);
    send(OP_START, 2'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++; if ({seg_done, done, cnt_en} !== 3'b100) begin bad++;
          $display("FAIL ena_seg0_zero got=%b want=100", {seg_done, done, cnt_en}); end
      end
      tick();
    end
    ena = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (f == 1) send(OP_START, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      else        cmd_valid = 1'b0;
      @(negedge clk);
      total++; if ({cnt_en, cnt_load, seg_done, done, err, cmd_ready} !== 6'b0 ||
                   seg_idx !== 2'd1 || busy !== 1'b1 || cnt_val !== 8'(s + 8'd3)) begin bad++;
        $display("FAIL ena_freeze f=%0d got=%b idx=%0d busy=%b cnt=%0d want=000000 1 1 %0d", f,
                 {cnt_en, cnt_load, seg_done, done, err, cmd_ready}, seg_idx, busy, cnt_val, 8'(s + 8'd3)); end
      tick();
    end
    cmd_valid = 1'b0;
    ena = 1'b1;
    got = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = n; break; end
      tick();
    end
    total++; if (got !== 7) begin bad++;
      $display("FAIL ena_resume got=%0d cycles want=7", got); end
    tick();
    $display("test_ena finished seg1_start=%0d", s);
  endtask

  task automatic test_clear();
    obs_t obs;
    write_seg(2, 8'd9, 8'd5, 1'b0);
    send(OP_START, 2'd2, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    send(OP_CLEAR, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    mdl_clear();
    @(negedge clk);
    total++; if ({cnt_load, cnt_en, seg_done, done} !== 4'b1000 || cnt_load_val !== 8'd0) begin bad++;
      $display("FAIL clear_strobe got=%b val=%0d want=1000 val=0", {cnt_load, cnt_en, seg_done, done}, cnt_load_val); end
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || seg_idx !== 2'd0 || cnt_up !== 1'b1 || cnt_load_val !== 8'd0 || cnt_val !== 8'd0) begin bad++;
      $display("FAIL clear_idle got busy=%b idx=%0d up=%b val=%0d cnt=%0d", busy, seg_idx, cnt_up, cnt_load_val, cnt_val); end
    // Every entry must now read {0,0,up}: a full run is LOAD 0 then one RUN cycle each
    send(OP_START, 2'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    build_trace(3, cnt_q);
    tick();
    cmd_valid = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      obs = {cnt_load, cnt_load_val, cnt_en, cnt_up, seg_done, done, busy, seg_idx, cnt_val};
      total++; if (obs !== exp_q[0]) begin bad++;
        $display("FAIL clear_table left=%0d got=%h want=%h", exp_q.size(), obs, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    $display("test_clear finished");
  endtask

  task automatic test_async_reset();
    write_seg(0, 8'd0, 8'd100, 1'b1);
    send(OP_START, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({cnt_en, busy, cnt_load, seg_done, done} !== 5'b0 || cnt_up !== 1'b1) begin bad++;
      $display("FAIL async_reset got=%b up=%b want=00000 up=1", {cnt_en, busy, cnt_load, seg_done, done}, cnt_up); end
    mdl_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    total++; if (busy !== 1'b0 || cnt_en !== 1'b0 || cnt_val !== 8'd0) begin bad++;
      $display("FAIL after_reset got busy=%b en=%b cnt=%0d want 0 0 0", busy, cnt_en, cnt_val); end
    tick();
    $display("test_async_reset finished");
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_repeat();
    test_busy_err();
    test_ena();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
